ahb_dual_master_arbiter: RTL and testbench

- AHB-Lite 2-master/1-slave arbiter that lets the instruction-fetch port (M0, if_code_*) and load/store port (M1, ldst_*) of riscv32ia share a single ahb_cache/memory slave.
- Tracks address-phase and data-phase ownership separately, muxes master signals onto the slave, and stalls the losing master through its HREADY.
- Sits between the core and a unified memory in riscv_top.

---
 rtl/ahb_dual_master_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ahb_dual_master_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dual_master_arbiter.sv
// AHB-Lite arbiter sharing one slave between an instruction-fetch master (M0) and a
// load/store master (M1); address and data phase ownership are tracked separately.
module ahb_dual_master_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [2:0]            m0_hsize,
  input  logic [2:0]            m0_hburst,
  input  logic [3:0]            m0_hprot,
  input  logic                  m0_hmastlock,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [2:0]            m1_hsize,
  input  logic [2:0]            m1_hburst,
  input  logic [3:0]            m1_hprot,
  input  logic                  m1_hmastlock,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [1:0]            s_htrans,
  output logic                  s_hwrite,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic [3:0]            s_hprot,
  output logic                  s_hmastlock,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  owner_e data_owner_q, data_owner_d;
  owner_e rr_last_q, rr_last_d;
  owner_e lock_owner_q, lock_owner_d;
  owner_e addr_owner_s;
  logic   m0_req_s, m1_req_s;
  logic   m0_burst_s, m1_burst_s;
  logic   addr_lock_s;

  assign m0_req_s   = m0_htrans[1];
  assign m1_req_s   = m1_htrans[1];
  // A data owner continuing its burst (SEQ or BUSY) keeps the address bus.
  assign m0_burst_s = (data_owner_q == OWN_M0) && ((m0_htrans == HTRANS_SEQ) || (m0_htrans == HTRANS_BUSY));
  assign m1_burst_s = (data_owner_q == OWN_M1) && ((m1_htrans == HTRANS_SEQ) || (m1_htrans == HTRANS_BUSY));

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_owner_q <= OWN_NONE;
      rr_last_q    <= OWN_M1;
      lock_owner_q <= OWN_NONE;
    end else begin
      data_owner_q <= data_owner_d;
      rr_last_q    <= rr_last_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  always_comb begin
    addr_owner_s = OWN_NONE;
    if (lock_owner_q != OWN_NONE) begin
      addr_owner_s = lock_owner_q;
    end else if (m0_burst_s) begin
      addr_owner_s = OWN_M0;
    end else if (m1_burst_s) begin
      addr_owner_s = OWN_M1;
    end else if (m0_req_s && m1_req_s) begin
      if (PRIORITY_MODE != 0) begin
        addr_owner_s = OWN_M1;
      end else if (rr_last_q == OWN_M0) begin
        addr_owner_s = OWN_M1;
      end else begin
        addr_owner_s = OWN_M0;
      end
    end else if (m0_req_s) begin
      addr_owner_s = OWN_M0;
    end else if (m1_req_s) begin
      addr_owner_s = OWN_M1;
    end else begin
      addr_owner_s = OWN_NONE;
    end
  end

  always_comb begin
    data_owner_d = data_owner_q;
    rr_last_d    = rr_last_q;
    lock_owner_d = lock_owner_q;
    case (addr_owner_s)
      OWN_M0:  addr_lock_s = m0_hmastlock;
      OWN_M1:  addr_lock_s = m1_hmastlock;
      default: addr_lock_s = 1'b0;
    endcase
    // Ownership only advances on an accepted transfer; a stalled slave freezes it.
    if (s_hready) begin
      data_owner_d = addr_owner_s;
      if (addr_owner_s != OWN_NONE) begin
        rr_last_d = addr_owner_s;
      end else begin
        rr_last_d = rr_last_q;
      end
      lock_owner_d = addr_lock_s ? addr_owner_s : OWN_NONE;
    end else begin
      data_owner_d = data_owner_q;
      rr_last_d    = rr_last_q;
      lock_owner_d = lock_owner_q;
    end
  end

  always_comb begin
    s_haddr     = '0;
    s_htrans    = HTRANS_IDLE;
    s_hwrite    = 1'b0;
    s_hsize     = 3'b000;
    s_hburst    = 3'b000;
    s_hprot     = 4'b0000;
    s_hmastlock = 1'b0;
    case (addr_owner_s)
      OWN_M0: begin
        s_haddr     = m0_haddr;
        s_htrans    = m0_htrans;
        s_hwrite    = m0_hwrite;
        s_hsize     = m0_hsize;
        s_hburst    = m0_hburst;
        s_hprot     = m0_hprot;
        s_hmastlock = m0_hmastlock;
      end
      OWN_M1: begin
        s_haddr     = m1_haddr;
        s_htrans    = m1_htrans;
        s_hwrite    = m1_hwrite;
        s_hsize     = m1_hsize;
        s_hburst    = m1_hburst;
        s_hprot     = m1_hprot;
        s_hmastlock = m1_hmastlock;
      end
      default: begin
        s_haddr  = '0;
        s_htrans = HTRANS_IDLE;
      end
    endcase
  end

  always_comb begin
    case (data_owner_q)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = '0;
    endcase
  end

  // A requesting master that lost the address bus is held off through its HREADY.
  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = 1'b0;
    if (data_owner_q == OWN_M0) begin
      m0_hready = s_hready && ((addr_owner_s == OWN_M0) || !m0_req_s);
      m0_hresp  = s_hresp;
    end else if (m0_req_s && (addr_owner_s != OWN_M0)) begin
      m0_hready = 1'b0;
    end else begin
      m0_hready = 1'b1;
    end
  end

  always_comb begin
    m1_hready = 1'b1;
    m1_hresp  = 1'b0;
    if (data_owner_q == OWN_M1) begin
      m1_hready = s_hready && ((addr_owner_s == OWN_M1) || !m1_req_s);
      m1_hresp  = s_hresp;
    end else if (m1_req_s && (addr_owner_s != OWN_M1)) begin
      m1_hready = 1'b0;
    end else begin
      m1_hready = 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Scoreboard bench for ahb_dual_master_arbiter: a round-robin instance plus a
// fixed-priority instance driven from the same master and slave stimulus.
module tb_ahb_dual_master_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready, s_hresp;

  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [1:0]  s_htrans;
  logic        s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;

  logic [31:0] fx_m0_hrdata, fx_m1_hrdata, fx_s_haddr, fx_s_hwdata;
  logic        fx_m0_hready, fx_m1_hready, fx_m0_hresp, fx_m1_hresp;
  logic [1:0]  fx_s_htrans;
  logic        fx_s_hwrite, fx_s_hmastlock;
  logic [2:0]  fx_s_hsize, fx_s_hburst;
  logic [3:0]  fx_s_hprot;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_rdata_q[$];
  logic [31:0] exp_val;

  always #5 CLK = ~CLK;

  ahb_dual_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut (
    .CLK(CLK), .RST(RST),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
    .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
    .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  ahb_dual_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_fx (
    .CLK(CLK), .RST(RST),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
    .m0_hrdata(fx_m0_hrdata), .m0_hready(fx_m0_hready), .m0_hresp(fx_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
    .m1_hrdata(fx_m1_hrdata), .m1_hready(fx_m1_hready), .m1_hresp(fx_m1_hresp),
    .s_haddr(fx_s_haddr), .s_htrans(fx_s_htrans), .s_hwrite(fx_s_hwrite), .s_hsize(fx_s_hsize),
    .s_hburst(fx_s_hburst), .s_hprot(fx_s_hprot), .s_hmastlock(fx_s_hmastlock), .s_hwdata(fx_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_masters();
    m0_haddr = 32'h0; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'b010; m0_hburst = 3'b000;
    m0_hprot = 4'b0011; m0_hmastlock = 1'b0; m0_hwdata = 32'h0;
    m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'b010; m1_hburst = 3'b000;
    m1_hprot = 4'b0011; m1_hmastlock = 1'b0; m1_hwdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_masters();
    s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    #4;
    n_total++; if (s_htrans !== 2'b00) $display("FAIL reset_htrans got=%b exp=00", s_htrans); else n_pass++;
    n_total++; if (s_haddr !== 32'h0) $display("FAIL reset_haddr got=%h exp=0", s_haddr); else n_pass++;
    n_total++; if (s_hwdata !== 32'h0) $display("FAIL reset_hwdata got=%h exp=0", s_hwdata); else n_pass++;
    n_total++; if ({m0_hready, m1_hready} !== 2'b11) $display("FAIL reset_hready got=%b exp=11", {m0_hready, m1_hready}); else n_pass++;
    n_total++; if ({m0_hresp, m1_hresp} !== 2'b00) $display("FAIL reset_hresp got=%b exp=00", {m0_hresp, m1_hresp}); else n_pass++;
    n_total++; if ({fx_s_htrans, fx_m0_hready, fx_m1_hready} !== 4'b0011) $display("FAIL reset_fx got=%b exp=0011", {fx_s_htrans, fx_m0_hready, fx_m1_hready}); else n_pass++;
    step();
  endtask

  task automatic test_tie_rr();
    m0_htrans = 2'b10; m0_haddr = 32'h100; m1_htrans = 2'b10; m1_haddr = 32'h2000;
    exp_addr_q.push_back(32'h100);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL tie0_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if (m1_hready !== 1'b0) $display("FAIL tie0_m1_stall got=%b exp=0", m1_hready); else n_pass++;
    step();
    m0_htrans = 2'b00;
    exp_addr_q.push_back(32'h2000);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL tie1_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if (m1_hready !== 1'b1) $display("FAIL tie1_m1_ready got=%b exp=1", m1_hready); else n_pass++;
    step();
    m0_htrans = 2'b10; m0_haddr = 32'h104; m1_haddr = 32'h2004;
    exp_addr_q.push_back(32'h104);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL tie2_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if ({m0_hready, m1_hready} !== 2'b10) $display("FAIL tie2_ready got=%b exp=10", {m0_hready, m1_hready}); else n_pass++;
    step();
    m0_htrans = 2'b00;
    exp_addr_q.push_back(32'h2004);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL tie3_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_single();
    m0_htrans = 2'b10; m0_haddr = 32'h100;
    exp_addr_q.push_back(32'h100);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL single_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if (s_htrans !== 2'b10) $display("FAIL single_htrans got=%b exp=10", s_htrans); else n_pass++;
    n_total++; if ({m0_hready, m1_hready} !== 2'b11) $display("FAIL single_ready got=%b exp=11", {m0_hready, m1_hready}); else n_pass++;
    step();
    m0_htrans = 2'b00; s_hready = 1'b0; s_hrdata = 32'hDEADBEEF;
    #4;
    n_total++; if ({m0_hready, m1_hready} !== 2'b01) $display("FAIL single_wait got=%b exp=01", {m0_hready, m1_hready}); else n_pass++;
    step();
    s_hready = 1'b1;
    exp_rdata_q.push_back(32'hDEADBEEF);
    #4;
    exp_val = exp_rdata_q.pop_front();
    n_total++; if (m0_hready !== 1'b1) $display("FAIL single_done got=%b exp=1", m0_hready); else n_pass++;
    n_total++; if (m0_hrdata !== exp_val) $display("FAIL single_rdata got=%h exp=%h", m0_hrdata, exp_val); else n_pass++;
    step();
    s_hrdata = 32'h0;
    step();
  endtask

  task automatic test_burst_hold();
    m0_htrans = 2'b10; m0_haddr = 32'h40; m0_hburst = 3'b011;
    exp_addr_q.push_back(32'h40);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL burst_beat0 got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    step();
    m1_htrans = 2'b10; m1_haddr = 32'h3000;
    for (int i = 1; i < 4; i++) begin
      m0_htrans = 2'b11; m0_haddr = 32'h40 + 32'(4 * i);
      exp_addr_q.push_back(32'h40 + 32'(4 * i));
      #4;
      exp_val = exp_addr_q.pop_front();
      n_total++; if (s_haddr !== exp_val) $display("FAIL burst_beat%0d got=%h exp=%h", i, s_haddr, exp_val); else n_pass++;
      n_total++; if (m1_hready !== 1'b0) $display("FAIL burst_m1_stall%0d got=%b exp=0", i, m1_hready); else n_pass++;
      step();
    end
    m0_htrans = 2'b00; m0_hburst = 3'b000;
    exp_addr_q.push_back(32'h3000);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL burst_m1_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if ({m0_hready, m1_hready} !== 2'b11) $display("FAIL burst_handover got=%b exp=11", {m0_hready, m1_hready}); else n_pass++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_wait_error();
    m1_htrans = 2'b10; m1_haddr = 32'h2100; m1_hwrite = 1'b1;
    #4;
    n_total++; if ({s_hwrite, s_haddr} !== {1'b1, 32'h2100}) $display("FAIL werr_addr got=%b/%h exp=1/2100", s_hwrite, s_haddr); else n_pass++;
    step();
    m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hwdata = 32'hCAFEF00D; s_hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      n_total++; if (s_hwdata !== 32'hCAFEF00D) $display("FAIL werr_wait_wdata%0d got=%h exp=cafef00d", i, s_hwdata); else n_pass++;
      n_total++; if ({m1_hready, m1_hresp, m0_hresp} !== 3'b000) $display("FAIL werr_wait%0d got=%b exp=000", i, {m1_hready, m1_hresp, m0_hresp}); else n_pass++;
      step();
    end
    s_hresp = 1'b1;
    #4;
    n_total++; if ({m1_hready, m1_hresp, m0_hresp} !== 3'b010) $display("FAIL werr_err1 got=%b exp=010", {m1_hready, m1_hresp, m0_hresp}); else n_pass++;
    n_total++; if (s_hwdata !== 32'hCAFEF00D) $display("FAIL werr_err1_wdata got=%h exp=cafef00d", s_hwdata); else n_pass++;
    step();
    s_hready = 1'b1;
    #4;
    n_total++; if ({m1_hready, m1_hresp, m0_hresp} !== 3'b110) $display("FAIL werr_err2 got=%b exp=110", {m1_hready, m1_hresp, m0_hresp}); else n_pass++;
    n_total++; if (s_hwdata !== 32'hCAFEF00D) $display("FAIL werr_err2_wdata got=%h exp=cafef00d", s_hwdata); else n_pass++;
    step();
    s_hresp = 1'b0; m1_hwdata = 32'h0;
    #4;
    n_total++; if (m1_hresp !== 1'b0) $display("FAIL werr_after got=%b exp=0", m1_hresp); else n_pass++;
    step();
  endtask

  task automatic test_fixed_priority();
    m0_htrans = 2'b10; m0_haddr = 32'h700;
    for (int i = 0; i < 4; i++) begin
      m1_htrans = 2'b10; m1_haddr = 32'h6000 + 32'(4 * i);
      exp_addr_q.push_back(32'h6000 + 32'(4 * i));
      #4;
      exp_val = exp_addr_q.pop_front();
      n_total++; if (fx_s_haddr !== exp_val) $display("FAIL fixed_addr%0d got=%h exp=%h", i, fx_s_haddr, exp_val); else n_pass++;
      n_total++; if (fx_m0_hready !== 1'b0) $display("FAIL fixed_m0_stall%0d got=%b exp=0", i, fx_m0_hready); else n_pass++;
      step();
    end
    m1_htrans = 2'b00;
    exp_addr_q.push_back(32'h700);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (fx_s_haddr !== exp_val) $display("FAIL fixed_m0_addr got=%h exp=%h", fx_s_haddr, exp_val); else n_pass++;
    n_total++; if (fx_m0_hready !== 1'b1) $display("FAIL fixed_m0_grant got=%b exp=1", fx_m0_hready); else n_pass++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_lock_reset();
    m1_htrans = 2'b10; m1_haddr = 32'h8000; m1_hmastlock = 1'b1;
    #4;
    n_total++; if (s_hmastlock !== 1'b1) $display("FAIL lock_hmastlock got=%b exp=1", s_hmastlock); else n_pass++;
    step();
    m1_haddr = 32'h8004; m0_htrans = 2'b10; m0_haddr = 32'h900;
    exp_addr_q.push_back(32'h8004);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL lock_pair_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if (m0_hready !== 1'b0) $display("FAIL lock_m0_stall got=%b exp=0", m0_hready); else n_pass++;
    step();
    m1_htrans = 2'b00; m1_hmastlock = 1'b0;
    #4;
    n_total++; if ({s_htrans, m0_hready} !== 3'b000) $display("FAIL lock_held got=%b exp=000", {s_htrans, m0_hready}); else n_pass++;
    step();
    exp_addr_q.push_back(32'h900);
    #4;
    exp_val = exp_addr_q.pop_front();
    n_total++; if (s_haddr !== exp_val) $display("FAIL lock_release_addr got=%h exp=%h", s_haddr, exp_val); else n_pass++;
    n_total++; if (m0_hready !== 1'b1) $display("FAIL lock_release_ready got=%b exp=1", m0_hready); else n_pass++;
    step();
    idle_masters();
    step();
    m1_htrans = 2'b10; m1_haddr = 32'h8100; m1_hmastlock = 1'b1;
    step();
    m1_haddr = 32'h8104;
    step();
    m1_htrans = 2'b00; m1_hmastlock = 1'b0; s_hready = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    #4;
    n_total++; if ({s_htrans, s_hmastlock} !== 3'b000) $display("FAIL rst_mid_bus got=%b exp=000", {s_htrans, s_hmastlock}); else n_pass++;
    n_total++; if ({m0_hready, m1_hready} !== 2'b11) $display("FAIL rst_mid_ready got=%b exp=11", {m0_hready, m1_hready}); else n_pass++;
    n_total++; if ({m0_hresp, m1_hresp} !== 2'b00) $display("FAIL rst_mid_resp got=%b exp=00", {m0_hresp, m1_hresp}); else n_pass++;
    s_hready = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie_rr();
    test_single();
    test_burst_hold();
    test_wait_error();
    test_fixed_priority();
    test_lock_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
